fb_port_arbiter: RTL
====================

Name: fb_port_arbiter

Overview:
- Shares one single-port 32K x 8 grayscale frame-buffer BRAM between two requesters: the display scan-out read path and the camera pixel write path.
- Display reads have strict priority because scan-out timing is fixed. Camera writes are buffered in a small FIFO and drained into idle BRAM cycles.
- A starvation guard forces a write slot if display traffic blocks writes too long.
- Sits between the pixel capture/writer logic, the LCD timing generator and the frame-buffer BRAM.

Parameters:
- ADDR_W, 15, BRAM address width.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.
- STARVE_MAX, 16, consecutive cycles a non-empty FIFO may be blocked before a write slot is forced; range 2..255.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_rdata  out  DATA_W  read data; valid when disp_rvalid=1.
- disp_rvalid  out  1  read data valid.
- disp_miss  out  1  pulse in the slot where a display read was dropped.
- wr_valid  in  1  writer has a pixel.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- bram_addr  out  ADDR_W  BRAM address.
- bram_we  out  1  BRAM write enable.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data; 1-cycle synchronous read.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- starve_events  out  8  saturating count of forced write slots.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied and contents discarded; all outputs 0, except wr_ready=1 once rst_n deasserts. Starve counter 0, starve_events 0. A reset mid-operation drops any in-flight read, so no disp_rvalid follows.
- Write FIFO:
  - wr_ready = !full.
  - Push on wr_valid & wr_ready.
  - Push and pop in the same cycle are both legal; level is unchanged.
  - No bypass: a pushed entry is eligible for pop no earlier than the next cycle.
- Arbitration is evaluated every cycle (slot N). The decision is registered onto bram_* at edge N+1.
  - GRANT_DISP: disp_req=1 and not forced → bram_addr<=disp_addr, bram_we<=0.
  - GRANT_WR: disp_req=0 and FIFO non-empty → pop head; bram_addr<=head addr, bram_wdata<=head data, bram_we<=1.
  - FORCE_WR: disp_req=1, FIFO non-empty, starve_cnt==STARVE_MAX-1 → same as GRANT_WR. The display request is dropped; starve_events increments, saturating at 255.
  - IDLE: no request → bram_we<=0; bram_addr holds its last value.
- Starve counter:
  - Increments in any slot where FIFO is non-empty and no pop occurs.
  - Clears on any pop, on FIFO empty, and in the FORCE_WR slot.
- Display read latency: disp_req in slot N → disp_rvalid=1 in cycle N+2, with disp_rdata = bram_rdata (registered copy).
  - Back-to-back requests produce back-to-back rvalids.
- Forced slot: disp_miss=1 in cycle N+2, disp_rvalid=0, disp_rdata holds its previous value.
- Read/write hazard: no forwarding. A display read of an address with a pending FIFO write returns the old BRAM content.
- Writes retire in FIFO order only.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=15 and FB_DATA_W=8, also used by the LCD and capture blocks.
  - FB_WORDS=32768.
  - Grant-type encoding: IDLE, GRANT_DISP, GRANT_WR, FORCE_WR.
- One natural sub-module: fb_wr_fifo. It is a synchronous FIFO (addr+data wide) with level output, instantiated once.

Test Plan:
1. Write only: push 4 pixels (addr 0x0010..0x0013, data 0xA0..0xA3) with disp_req=0.
   - → bram_we pulses 4 consecutive cycles starting 2 cycles after the first push, in order.
   - → fifo_level returns to 0.
   - → starve_events=0.
2. Display only: disp_req=1 for 8 cycles, addr 0..7, BRAM preloaded with data=addr.
   - → disp_rvalid high 8 cycles starting at cycle 2, disp_rdata=0..7.
   - → bram_we=0 throughout.
3. Interleaved 50% duty: disp_req toggles every cycle (LCD pixel-clock pattern) while the writer streams 16 pixels.
   - → all 16 writes land in the odd slots.
   - → no disp_miss.
   - → wr_ready never falls.
4. Starvation: FIFO holds 1 entry, disp_req held at 1 for 40 cycles, STARVE_MAX=16.
   - → exactly 1 forced write at blocked-slot 16.
   - → disp_miss single pulse 2 cycles later.
   - → starve_events=1.
   - → remaining reads valid.
5. Full FIFO: disp_req held at 1, writer pushes 6 pixels.
   - → wr_ready falls after the 4th push.
   - → fifo_level=4.
   - → the 5th pixel is held until the forced slot pops, then accepted.
   - → data order preserved in BRAM.
6. Reset mid-operation: assert rst_n with fifo_level=3 and a read in flight.
   - → all outputs 0 asynchronously.
   - → no disp_rvalid after release.
   - → the 3 pending writes never reach the BRAM.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer widths, depth and arbiter grant encoding
package fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;
    localparam int FB_WORDS  = 32768;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_DISP = 2'd1,
        GRANT_WR   = 2'd2,
        FORCE_WR   = 2'd3
    } fb_grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous address+data write FIFO with occupancy output
module fb_wr_fifo #(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [AW-1:0]          push_addr,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [AW-1:0]          head_addr,
    output logic [DW-1:0]          head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; a reset only rewinds the pointers, discarding contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr];

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - display-priority arbiter sharing one frame-buffer BRAM port with buffered camera writes
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [DATA_W-1:0]             disp_rdata,
    output logic                          disp_rvalid,
    output logic                          disp_miss,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic                          bram_we,
    output logic [DATA_W-1:0]             bram_wdata,
    input  logic [DATA_W-1:0]             bram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    starve_events
);

    localparam int SW = $clog2(STARVE_MAX);

    fb_grant_e         grant;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [SW-1:0]     starve_cnt;
    logic              rd_pend;
    logic              miss_pend;
    logic [DATA_W-1:0] rdata_q;

    assign wr_ready = rst_n && !fifo_full;
    assign push     = wr_valid && !fifo_full;
    assign pop      = (grant == GRANT_WR) || (grant == FORCE_WR);

    fb_wr_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        grant = IDLE;
        if (disp_req && !fifo_empty && (starve_cnt == SW'(STARVE_MAX - 1))) begin
            grant = FORCE_WR;
        end else if (disp_req) begin
            grant = GRANT_DISP;
        end else if (!fifo_empty) begin
            grant = GRANT_WR;
        end
    end

    // Two-stage read pipe: address lands on the BRAM one cycle after the slot, data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr     <= '0;
            bram_we       <= 1'b0;
            bram_wdata    <= '0;
            rd_pend       <= 1'b0;
            miss_pend     <= 1'b0;
            disp_rvalid   <= 1'b0;
            disp_miss     <= 1'b0;
            rdata_q       <= '0;
            starve_cnt    <= '0;
            starve_events <= '0;
        end else begin
            bram_we   <= pop;
            rd_pend   <= (grant == GRANT_DISP);
            miss_pend <= (grant == FORCE_WR);
            if (grant == GRANT_DISP) begin
                bram_addr <= disp_addr;
            end else if (pop) begin
                bram_addr  <= head_addr;
                bram_wdata <= head_data;
            end

            disp_rvalid <= rd_pend;
            disp_miss   <= miss_pend;
            if (disp_rvalid) begin
                rdata_q <= bram_rdata;
            end

            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if ((grant == FORCE_WR) && (starve_events != 8'hFF)) begin
                starve_events <= starve_events + 8'd1;
            end
        end
    end

    // Live BRAM data in the valid cycle, otherwise the last delivered pixel is held.
    assign disp_rdata = disp_rvalid ? bram_rdata : rdata_q;

endmodule
